// File: rtl/cell_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cell_pkg
//  Description : Shared lane type, FSM state encoding, precharge constant and
//                output fold helper for the cell evaluation array.
//  Revision    : 1.0 - initial release
// ============================================================================
package cell_pkg;

    typedef logic [7:0] lane_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVA  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Value forced into lane bits [7:6] of precharged rows.
    localparam logic [1:0] PRE_BITS = 2'b11;

    // Output fold: top two bits come from the inverted low bits of the
    // evaluated lane, the low six bits pass straight through.
    function automatic lane_t fold_lane(input lane_t x);
        return {~x[1:0], x[5:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_eval_comb.sv
`default_nettype none
// ============================================================================
//  Module      : cell_eval_comb
//  Description : Combinational evaluate stage. Each lane is OR-ed with the
//                same lane of every row within REACH (window clipped at the
//                array edges, no wrap-around), then folded.
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_eval_comb
    import cell_pkg::*;
#(
    parameter int ROWS  = 12,
    parameter int WIDTH = 1,
    parameter int REACH = 9
) (
    input  logic [ROWS-1:0][WIDTH-1:0][7:0] rows_in,
    output logic [ROWS-1:0][WIDTH-1:0][7:0] rows_out
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        // Neighbour window bounds resolved at elaboration time.
        localparam int LO = (r >= REACH) ? (r - REACH) : 0;
        localparam int HI = ((r + REACH) > (ROWS - 1)) ? (ROWS - 1) : (r + REACH);

        for (genvar a = 0; a < WIDTH; a++) begin : g_lane
            lane_t w_iow;

            // OR the lane across the clipped neighbour window.
            always_comb begin
                w_iow = '0;
                for (int s = LO; s <= HI; s++) begin
                    w_iow = w_iow | rows_in[s][a];
                end
            end

            assign rows_out[r][a] = fold_lane(w_iow);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cell_eval_array.sv
`default_nettype none
// ============================================================================
//  Module      : cell_eval_array
//  Description : Single-clock precharge / evaluate / fold engine over a
//                ROWS x WIDTH array of 8-bit lanes with valid/ready
//                handshakes on both sides. FSM: IDLE -> PRE -> EVA -> OUT.
//                Optional build macro CELL_MULTIPASS_EN adds a 'passes'
//                input that loops PRE/EVA several times before output.
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_eval_array
    import cell_pkg::*;
#(
    parameter int              ROWS      = 12,
    parameter int              WIDTH     = 1,
    parameter int              REACH     = 9,
    parameter logic [ROWS-1:0] PRECHARGE = '1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ROWS-1:0][WIDTH-1:0][7:0] in_data,
`ifdef CELL_MULTIPASS_EN
    input  logic [3:0]                      passes,
`endif
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ROWS-1:0][WIDTH-1:0][7:0] out_data,
    output logic                            busy
);

    state_t r_state;
    state_t w_next_state;

    logic [ROWS-1:0][WIDTH-1:0][7:0] r_rows;
    logic [ROWS-1:0][WIDTH-1:0][7:0] r_out_data;
    logic [ROWS-1:0][WIDTH-1:0][7:0] w_pre_rows;
    logic [ROWS-1:0][WIDTH-1:0][7:0] w_eval;
    logic                            w_more_passes;

    // Precharge: masked rows get their top two bits forced high.
    for (genvar r = 0; r < ROWS; r++) begin : g_pre_row
        for (genvar a = 0; a < WIDTH; a++) begin : g_pre_lane
            if (PRECHARGE[r]) begin : g_set
                assign w_pre_rows[r][a] = {PRE_BITS, r_rows[r][a][5:0]};
            end else begin : g_keep
                assign w_pre_rows[r][a] = r_rows[r][a];
            end
        end
    end

    cell_eval_comb #(
        .ROWS  (ROWS),
        .WIDTH (WIDTH),
        .REACH (REACH)
    ) u_eval (
        .rows_in  (r_rows),
        .rows_out (w_eval)
    );

`ifdef CELL_MULTIPASS_EN
    logic [3:0] r_passes;
    logic [3:0] r_pass_cnt;

    // Another loop is needed while fewer than passes-1 write-backs have run.
    assign w_more_passes = (r_pass_cnt < (r_passes - 4'd1));

    // Pass bookkeeping; a request of zero passes behaves as one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_passes   <= 4'd1;
            r_pass_cnt <= 4'd0;
        end else if (r_state == IDLE && in_valid) begin
            r_passes   <= (passes == 4'd0) ? 4'd1 : passes;
            r_pass_cnt <= 4'd0;
        end else if (r_state == EVA && w_more_passes) begin
            r_pass_cnt <= r_pass_cnt + 4'd1;
        end
    end
`else
    assign w_more_passes = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = PRE;
            PRE:     w_next_state = EVA;
            EVA:     w_next_state = w_more_passes ? PRE : OUT;
            OUT:     if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Row register and result register; reset discards any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rows     <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) r_rows <= in_data;
                PRE:  r_rows <= w_pre_rows;
                EVA: begin
                    if (w_more_passes) begin
                        r_rows <= w_eval;
                    end else begin
                        r_out_data <= w_eval;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_cell_eval_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_eval_array
//  Description : Self-checking bench for cell_eval_array. Several instances
//                with different REACH/PRECHARGE settings share stimulus;
//                expected results come from a behavioural model queued at
//                input accept and compared when out_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_eval_array;

`ifdef CELL_MULTIPASS_EN
    localparam int NDUT = 4;
`else
    localparam int NDUT = 3;
`endif

    logic             clk;
    logic             rst;
    logic [NDUT-1:0]  vld;
    logic             out_ready;
    logic [95:0]      in_data;
`ifdef CELL_MULTIPASS_EN
    logic [3:0]       passes;
`endif

    logic        ov [NDUT];
    logic        ir [NDUT];
    logic        bz [NDUT];
    logic [95:0] od [NDUT];

    int errors = 0;
    int checks = 0;

    logic [95:0] exp_q [$];
    int          lat_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: REACH=9, all rows precharged
    cell_eval_array #(.ROWS(12), .WIDTH(1), .REACH(9), .PRECHARGE(12'hFFF)) u_a (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(ir[0]), .in_data(in_data),
`ifdef CELL_MULTIPASS_EN
        .passes(passes),
`endif
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));

    // B: REACH=9, no precharge
    cell_eval_array #(.ROWS(12), .WIDTH(1), .REACH(9), .PRECHARGE(12'h000)) u_b (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(ir[1]), .in_data(in_data),
`ifdef CELL_MULTIPASS_EN
        .passes(passes),
`endif
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));

    // C: REACH=0, no precharge
    cell_eval_array #(.ROWS(12), .WIDTH(1), .REACH(0), .PRECHARGE(12'h000)) u_c (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(ir[2]), .in_data(in_data),
`ifdef CELL_MULTIPASS_EN
        .passes(passes),
`endif
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));

`ifdef CELL_MULTIPASS_EN
    // D: REACH=1, no precharge, multipass
    cell_eval_array #(.ROWS(12), .WIDTH(1), .REACH(1), .PRECHARGE(12'h000)) u_d (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(ir[3]), .in_data(in_data),
        .passes(passes),
        .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .busy(bz[3]));
`endif

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural reference: precharge by OR-ing 0xC0, clipped window OR, fold.
    function automatic logic [95:0] model(input logic [95:0] din, input int reach,
                                          input logic [11:0] pre, input int np);
        logic [7:0]  cur [12];
        logic [7:0]  nxt [12];
        logic [7:0]  acc;
        logic [95:0] res;
        for (int r = 0; r < 12; r++) cur[r] = din[r*8 +: 8];
        for (int p = 0; p < np; p++) begin
            for (int r = 0; r < 12; r++) if (pre[r]) cur[r] = cur[r] | 8'hC0;
            for (int r = 0; r < 12; r++) begin
                acc = 8'h00;
                for (int s = 0; s < 12; s++)
                    if ((s >= r - reach) && (s <= r + reach)) acc = acc | cur[s];
                nxt[r] = {~acc[1], ~acc[0], acc[5:0]};
            end
            for (int r = 0; r < 12; r++) cur[r] = nxt[r];
        end
        for (int r = 0; r < 12; r++) res[r*8 +: 8] = cur[r];
        return res;
    endfunction

    task automatic send(input int d, input logic [95:0] data, input int reach,
                        input logic [11:0] pre, input logic [3:0] p);
        int np;
        np = (p == 4'd0) ? 1 : int'(p);
        @(negedge clk);
        chk("in_ready_before_accept", ir[d], 1'b1);
        in_data = data;
`ifdef CELL_MULTIPASS_EN
        passes = p;
`endif
        vld[d] = 1'b1;
        exp_q.push_back(model(data, reach, pre, np));
        lat_q.push_back(1 + 2 * np);
        @(posedge clk);
        #1 vld[d] = 1'b0;
    endtask

    task automatic recv(input int d, input int hold, output logic [95:0] got);
        int          lat;
        logic        seen;
        logic [95:0] expv;
        int          el;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = ov[d];
        end
        chk("out_valid_timeout", seen, 1'b1);
        expv = exp_q.pop_front();
        el   = lat_q.pop_front();
        got  = od[d];
        chk("latency", lat, el);
        chk("out_data", od[d], expv);
        chk("in_ready_while_out", ir[d], 1'b0);
        chk("busy_while_out", bz[d], 1'b1);
        for (int h = 0; h < hold; h++) begin
            in_data = ~in_data;
            vld[d]  = 1'b1;
            @(negedge clk);
            chk("hold_out_valid", ov[d], 1'b1);
            chk("hold_out_data", od[d], expv);
            chk("hold_in_ready", ir[d], 1'b0);
        end
        vld[d]    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("after_hs_out_valid", ov[d], 1'b0);
        chk("after_hs_in_ready", ir[d], 1'b1);
        chk("after_hs_busy", bz[d], 1'b0);
    endtask

    initial begin
        logic [95:0] got;
        logic [95:0] got1;
        logic [95:0] rnd;

        rst       = 1'b1;
        vld       = '0;
        out_ready = 1'b0;
        in_data   = '0;
`ifdef CELL_MULTIPASS_EN
        passes    = 4'd1;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_out_valid", ov[d], 1'b0);
            chk("reset_in_ready", ir[d], 1'b1);
            chk("reset_busy", bz[d], 1'b0);
            chk("reset_out_data", od[d], 96'h0);
        end

        // All zeros with full precharge -> every lane 0xC0.
        send(0, 96'h0, 9, 12'hFFF, 4'd1);
        recv(0, 0, got);
        chk("a_all_c0", got, {12{8'hC0}});

        // Row0=0x01, REACH=9, no precharge: rows 0..9 = 0x81, rows 10,11 = 0xC0.
        send(1, 96'h01, 9, 12'h000, 4'd1);
        recv(1, 0, got);
        chk("b_edge_clip", got, {8'hC0, 8'hC0, {10{8'h81}}});

        // Random patterns on A and B.
        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            send(0, rnd, 9, 12'hFFF, 4'd1);
            recv(0, 0, got);
            rnd = {$urandom, $urandom, $urandom};
            send(1, rnd, 9, 12'h000, 4'd1);
            recv(1, 0, got);
        end

        // REACH=0 fold only, with a 5-cycle back-pressure hold.
        send(2, {6{8'h3F, 8'h05}}, 0, 12'h000, 4'd1);
        recv(2, 5, got);
        chk("c_fold", got, {6{8'h3F, 8'h85}});

        // Reset while in EVA discards the transaction.
        send(0, {$urandom, $urandom, $urandom}, 9, 12'hFFF, 4'd1);
        @(negedge clk);
        chk("mid_pre_busy", bz[0], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge clk);
        chk("rst_eva_out_valid", ov[0], 1'b0);
        chk("rst_eva_out_data", od[0], 96'h0);
        chk("rst_eva_in_ready", ir[0], 1'b1);
        chk("rst_eva_busy", bz[0], 1'b0);
        send(0, 96'h0000_0000_0000_0000_0000_0003, 9, 12'hFFF, 4'd1);
        recv(0, 0, got);

`ifdef CELL_MULTIPASS_EN
        // Single pass on D: row2 becomes 0xC0.
        send(3, 96'h01, 1, 12'h000, 4'd1);
        recv(3, 0, got1);
        chk("mp_pass1_row2", got1[23:16], 8'hC0);
        // Two passes: row2 = 0x81, row3 = 0xC0, latency 5.
        send(3, 96'h01, 1, 12'h000, 4'd2);
        recv(3, 0, got);
        chk("mp_pass2_row2", got[23:16], 8'h81);
        chk("mp_pass2_row3", got[31:24], 8'hC0);
        // passes=0 behaves as one pass.
        send(3, 96'h01, 1, 12'h000, 4'd0);
        recv(3, 0, got);
        chk("mp_pass0_eq_pass1", got, got1);
        // Three passes on random data.
        send(3, {$urandom, $urandom, $urandom}, 1, 12'h000, 4'd3);
        recv(3, 0, got);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
